// File: rtl/execute_and_store_back.sv
// -----------------------------------------------------------------------------
// execute_and_store_back
//
// Execute / write-back stage of the 3-stage pipeline. Runs the ALU operation,
// load or store for the decoded instruction from fetch/decode. Drives the
// register-file write port, the data-memory request interface and the
// processor status word (PSW). Supports one-level forwarding of the last
// written result and a sticky HALT (powerdown) state.
//
// Optional feature macro: EXEC_MUL_EN
//   defined   : opcode 4 is a 16x16 multiply (low 16 bits written, Z/N set)
//   undefined : no multiplier; opcode 4 behaves exactly like NOP
//
// Ports:
//   clk                  in   1   system clock, rising edge
//   rst                  in   1   asynchronous active-low reset
//   opcode               in   4   instruction opcode
//   destReg              in   4   destination register index
//   srcVal1              in  16   operand 1 (also store data)
//   srcVal2              in  16   operand 2
//   memAddr              in   8   load/store address
//   used1 / used2        in   1   replace operand 1/2 with the last result
//   destRegStore         out  4   register-file write index
//   destVal              out 16   register-file write data
//   storeNow             out  1   register-file write request
//   storeDone            in   1   register-file write acknowledge
//   memAddrLoadStore     out  8   data-memory address
//   memValueStore        out 16   data-memory write data
//   memValueLoad         in  16   data-memory read data
//   valueReady           in   1   memory completion (read valid / write done)
//   readReq / writeReq   out  1   memory read / write request
//   ProcessorStatusWord  out 16   PSW {12'b0, V, N, Z, C}
//   powerdown            out  1   processor halted
// -----------------------------------------------------------------------------
module execute_and_store_back (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic [3:0]  destReg,
    input  logic [15:0] srcVal1,
    input  logic [15:0] srcVal2,
    input  logic [7:0]  memAddr,
    input  logic        used1,
    input  logic        used2,
    output logic [3:0]  destRegStore,
    output logic [15:0] destVal,
    output logic        storeNow,
    input  logic        storeDone,
    output logic [7:0]  memAddrLoadStore,
    output logic [15:0] memValueStore,
    input  logic [15:0] memValueLoad,
    input  logic        valueReady,
    output logic        readReq,
    output logic        writeReq,
    output logic [15:0] ProcessorStatusWord,
    output logic        powerdown
);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_HALT  = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_NOT   = 4'd9;
    localparam logic [3:0] OP_SHR   = 4'd10;
    localparam logic [3:0] OP_ASR   = 4'd11;
    localparam logic [3:0] OP_CMP   = 4'd12;
    localparam logic [3:0] OP_MOV   = 4'd13;
    localparam logic [3:0] OP_LOAD  = 4'd14;
    localparam logic [3:0] OP_STORE = 4'd15;

    typedef enum logic [1:0] {
        EXEC    = 2'd0,
        WAIT_LD = 2'd1,
        WAIT_ST = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  dest_reg_store_q, dest_reg_store_d;
    logic [15:0] dest_val_q, dest_val_d;
    logic        store_now_q, store_now_d;
    logic [7:0]  mem_addr_q, mem_addr_d;
    logic [15:0] mem_value_store_q, mem_value_store_d;
    logic        read_req_q, read_req_d;
    logic        write_req_q, write_req_d;
    logic [15:0] psw_q, psw_d;
    logic        powerdown_q, powerdown_d;
    logic [15:0] last_result_q, last_result_d;
    // Load destination is held separately: a previous ALU write may still be
    // pending on destRegStore while the load is outstanding.
    logic [3:0]  ld_dest_q, ld_dest_d;

    // ---------------------------------------------------------------------
    // Operand selection and ALU
    // ---------------------------------------------------------------------
    logic [15:0] op1, op2;
    logic [16:0] sum17;
    logic [15:0] diff;
    logic [15:0] alu_res;
    logic        alu_c, alu_v;
    logic        alu_wb;     // result goes to the register file
    logic        alu_flags;  // result updates the PSW

    assign op1   = used1 ? last_result_q : srcVal1;
    assign op2   = used2 ? last_result_q : srcVal2;
    assign sum17 = {1'b0, op1} + {1'b0, op2};
    assign diff  = op1 - op2;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case statements can leave it unassigned and infer
    // a latch.
    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_wb    = 1'b0;
        alu_flags = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res   = sum17[15:0];
                alu_c     = sum17[16];
                // Overflow: operands share a sign that the result does not.
                alu_v     = (op1[15] == op2[15]) && (alu_res[15] != op1[15]);
                alu_wb    = 1'b1;
                alu_flags = 1'b1;
            end
            OP_SUB: begin
                alu_res   = diff;
                alu_c     = (op1 < op2);
                // Overflow: operands differ in sign and result flips op1's.
                alu_v     = (op1[15] != op2[15]) && (alu_res[15] != op1[15]);
                alu_wb    = 1'b1;
                alu_flags = 1'b1;
            end
            OP_MUL: begin
`ifdef EXEC_MUL_EN
                alu_res   = op1 * op2;
                alu_wb    = 1'b1;
                alu_flags = 1'b1;
`endif
            end
            OP_AND: begin alu_res = op1 & op2;  alu_wb = 1'b1; alu_flags = 1'b1; end
            OP_OR:  begin alu_res = op1 | op2;  alu_wb = 1'b1; alu_flags = 1'b1; end
            OP_XOR: begin alu_res = op1 ^ op2;  alu_wb = 1'b1; alu_flags = 1'b1; end
            OP_SHL: begin alu_res = op1 << op2[3:0]; alu_wb = 1'b1; alu_flags = 1'b1; end
            OP_NOT: begin alu_res = ~op1;       alu_wb = 1'b1; alu_flags = 1'b1; end
            OP_SHR: begin alu_res = op1 >> op2[3:0]; alu_wb = 1'b1; alu_flags = 1'b1; end
            OP_ASR: begin
                alu_res   = $unsigned($signed(op1) >>> op2[3:0]);
                alu_wb    = 1'b1;
                alu_flags = 1'b1;
            end
            OP_CMP: begin
                // Compare only: flags from op1-op2, carry/overflow stay clear.
                alu_res   = diff;
                alu_flags = 1'b1;
            end
            OP_MOV: begin alu_res = op1; alu_wb = 1'b1; end
            default: ;  // NOP, HALT, LOAD, STORE handled by the FSM
        endcase
    end

    // ---------------------------------------------------------------------
    // Next-state / output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d           = state_q;
        dest_reg_store_d  = dest_reg_store_q;
        dest_val_d        = dest_val_q;
        // A pending write drops once the register file acknowledges it; a
        // new write on the same edge takes priority below.
        store_now_d       = store_now_q & ~storeDone;
        mem_addr_d        = mem_addr_q;
        mem_value_store_d = mem_value_store_q;
        read_req_d        = read_req_q;
        write_req_d       = write_req_q;
        psw_d             = psw_q;
        powerdown_d       = powerdown_q;
        last_result_d     = last_result_q;
        ld_dest_d         = ld_dest_q;

        case (state_q)
            EXEC: begin
                if (alu_wb) begin
                    dest_reg_store_d = destReg;
                    dest_val_d       = alu_res;
                    store_now_d      = 1'b1;
                    last_result_d    = alu_res;
                end
                if (alu_flags) begin
                    psw_d = {12'b0, alu_v, alu_res[15], (alu_res == 16'd0), alu_c};
                end
                case (opcode)
                    OP_HALT: begin
                        powerdown_d = 1'b1;
                        state_d     = HALT;
                    end
                    OP_LOAD: begin
                        mem_addr_d = memAddr;
                        read_req_d = 1'b1;
                        ld_dest_d  = destReg;
                        state_d    = WAIT_LD;
                    end
                    OP_STORE: begin
                        mem_addr_d        = memAddr;
                        mem_value_store_d = op1;
                        write_req_d       = 1'b1;
                        state_d           = WAIT_ST;
                    end
                    default: ;
                endcase
            end
            WAIT_LD: begin
                if (valueReady) begin
                    read_req_d       = 1'b0;
                    dest_val_d       = memValueLoad;
                    dest_reg_store_d = ld_dest_q;
                    store_now_d      = 1'b1;
                    last_result_d    = memValueLoad;
                    state_d          = EXEC;
                end
            end
            WAIT_ST: begin
                if (valueReady) begin
                    write_req_d = 1'b0;
                    state_d     = EXEC;
                end
            end
            HALT: ;  // sticky until reset; only the pending write can retire
            default: state_d = EXEC;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // flop samples the values from before the edge, independent of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= EXEC;
            dest_reg_store_q  <= '0;
            dest_val_q        <= '0;
            store_now_q       <= 1'b0;
            mem_addr_q        <= '0;
            mem_value_store_q <= '0;
            read_req_q        <= 1'b0;
            write_req_q       <= 1'b0;
            psw_q             <= '0;
            powerdown_q       <= 1'b0;
            last_result_q     <= '0;
            ld_dest_q         <= '0;
        end else begin
            state_q           <= state_d;
            dest_reg_store_q  <= dest_reg_store_d;
            dest_val_q        <= dest_val_d;
            store_now_q       <= store_now_d;
            mem_addr_q        <= mem_addr_d;
            mem_value_store_q <= mem_value_store_d;
            read_req_q        <= read_req_d;
            write_req_q       <= write_req_d;
            psw_q             <= psw_d;
            powerdown_q       <= powerdown_d;
            last_result_q     <= last_result_d;
            ld_dest_q         <= ld_dest_d;
        end
    end

    assign destRegStore        = dest_reg_store_q;
    assign destVal             = dest_val_q;
    assign storeNow            = store_now_q;
    assign memAddrLoadStore    = mem_addr_q;
    assign memValueStore       = mem_value_store_q;
    assign readReq             = read_req_q;
    assign writeReq            = write_req_q;
    assign ProcessorStatusWord = psw_q;
    assign powerdown           = powerdown_q;

endmodule

// File: tb/tb_execute_and_store_back.sv
// -----------------------------------------------------------------------------
// tb_execute_and_store_back
//
// Directed bench for execute_and_store_back. Expected register-file writes
// (index, data, PSW) are pushed to a scoreboard queue when the instruction is
// driven and popped when storeNow is observed; memory interface, PSW-only and
// halt/reset behaviour are checked against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_execute_and_store_back;

    localparam logic [3:0] NOP = 4'd0,  HLT = 4'd1,  ADD = 4'd2,  SUB = 4'd3;
    localparam logic [3:0] MUL = 4'd4,  AND = 4'd5,  OR_ = 4'd6,  XOR = 4'd7;
    localparam logic [3:0] SHL = 4'd8,  NOT = 4'd9,  SHR = 4'd10, ASR = 4'd11;
    localparam logic [3:0] CMP = 4'd12, MOV = 4'd13, LD  = 4'd14, ST  = 4'd15;

`ifdef EXEC_MUL_EN
    localparam logic [15:0] PSW_AFTER_MUL = 16'h0000;
`else
    localparam logic [15:0] PSW_AFTER_MUL = 16'h0002;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  opcode;
    logic [3:0]  destReg;
    logic [15:0] srcVal1;
    logic [15:0] srcVal2;
    logic [7:0]  memAddr;
    logic        used1;
    logic        used2;
    logic [3:0]  destRegStore;
    logic [15:0] destVal;
    logic        storeNow;
    logic        storeDone;
    logic [7:0]  memAddrLoadStore;
    logic [15:0] memValueStore;
    logic [15:0] memValueLoad;
    logic        valueReady;
    logic        readReq;
    logic        writeReq;
    logic [15:0] ProcessorStatusWord;
    logic        powerdown;

    execute_and_store_back dut (
        .clk                 (clk),
        .rst                 (rst),
        .opcode              (opcode),
        .destReg             (destReg),
        .srcVal1             (srcVal1),
        .srcVal2             (srcVal2),
        .memAddr             (memAddr),
        .used1               (used1),
        .used2               (used2),
        .destRegStore        (destRegStore),
        .destVal             (destVal),
        .storeNow            (storeNow),
        .storeDone           (storeDone),
        .memAddrLoadStore    (memAddrLoadStore),
        .memValueStore       (memValueStore),
        .memValueLoad        (memValueLoad),
        .valueReady          (valueReady),
        .readReq             (readReq),
        .writeReq            (writeReq),
        .ProcessorStatusWord (ProcessorStatusWord),
        .powerdown           (powerdown)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  dest;
        logic [15:0] val;
        logic [15:0] psw;
    } wb_t;

    wb_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic [15:0] v, input logic [15:0] p);
        wb_t e;
        e.dest = d; e.val = v; e.psw = p;
        sb.push_back(e);
    endtask

    // Drive one instruction at the falling edge, then sample 1 ns after the
    // following rising edge.
    task automatic issue(input logic [3:0] op, input logic [3:0] dst = 4'd0,
                         input logic [15:0] a = 16'd0, input logic [15:0] b = 16'd0,
                         input logic u1 = 1'b0, input logic u2 = 1'b0,
                         input logic [7:0] addr = 8'd0);
        @(negedge clk);
        opcode = op; destReg = dst; srcVal1 = a; srcVal2 = b;
        used1 = u1; used2 = u2; memAddr = addr;
        @(posedge clk);
        #1;
    endtask

    // A write is expected now: pop the scoreboard and compare.
    task automatic expect_wb(input string tag);
        wb_t e;
        chk({tag, " storeNow"}, storeNow, 1);
        chk({tag, " sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " destRegStore"}, destRegStore, e.dest);
            chk({tag, " destVal"}, destVal, e.val);
            chk({tag, " PSW"}, ProcessorStatusWord, e.psw);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {destRegStore, destVal, storeNow, memAddrLoadStore, memValueStore,
                readReq, writeReq, ProcessorStatusWord, powerdown};
    endfunction

    task automatic release_reset();
        @(negedge clk);
        opcode = NOP; used1 = 1'b0; used2 = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; opcode = NOP; destReg = '0; srcVal1 = '0; srcVal2 = '0;
        memAddr = '0; used1 = 1'b0; used2 = 1'b0; storeDone = 1'b0;
        memValueLoad = '0; valueReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", all_outs(), 0);
        release_reset();

        // Basic ADD; write held until acknowledged.
        push(4'd12, 16'd54, 16'h0000);
        issue(ADD, 4'd12, 16'd24, 16'd30);
        expect_wb("add_basic");
        issue(NOP);
        chk("storeNow held", storeNow, 1);
        storeDone = 1'b1;
        issue(NOP);
        chk("storeNow cleared", storeNow, 0);

        // ADD / SUB flag corners.
        push(4'd1, 16'hBFFF, 16'h0005); issue(ADD, 4'd1, 16'hC000, 16'hFFFF); expect_wb("add_cn");
        push(4'd2, 16'h7FFF, 16'h0009); issue(ADD, 4'd2, 16'hFFFF, 16'h8000); expect_wb("add_cv");
        push(4'd3, 16'h0000, 16'h0002); issue(ADD, 4'd3, 16'h0000, 16'h0000); expect_wb("add_z");
        push(4'd4, 16'd16,   16'h0000); issue(SUB, 4'd4, 16'd25,   16'd9);    expect_wb("sub_basic");
        push(4'd5, 16'h7FFF, 16'h0008); issue(SUB, 4'd5, 16'h8000, 16'h0001); expect_wb("sub_v");
        push(4'd6, 16'hFFFC, 16'h0005); issue(SUB, 4'd6, 16'd5,    16'd9);    expect_wb("sub_borrow");

        // Forwarding of the last result into both operands.
        push(4'd7, 16'd54,  16'h0000); issue(ADD, 4'd7, 16'd24, 16'd30); expect_wb("fwd_src");
        push(4'd8, 16'd108, 16'h0000); issue(ADD, 4'd8, 16'hDEAD, 16'hBEEF, 1'b1, 1'b1); expect_wb("fwd_both");

        // Logic, shift and move operations.
        push(4'd9,  16'h00F0, 16'h0000); issue(AND, 4'd9,  16'hF0F0, 16'h0FF0); expect_wb("and");
        push(4'd10, 16'hF00F, 16'h0004); issue(OR_, 4'd10, 16'hF000, 16'h000F); expect_wb("or");
        push(4'd11, 16'h0000, 16'h0002); issue(XOR, 4'd11, 16'hAAAA, 16'hAAAA); expect_wb("xor");
        push(4'd12, 16'h8000, 16'h0004); issue(SHL, 4'd12, 16'h0001, 16'h001F); expect_wb("shl");
        push(4'd13, 16'hFF00, 16'h0004); issue(NOT, 4'd13, 16'h00FF, 16'h1234); expect_wb("not");
        push(4'd14, 16'h0800, 16'h0000); issue(SHR, 4'd14, 16'h8000, 16'h0004); expect_wb("shr");
        push(4'd15, 16'hF800, 16'h0004); issue(ASR, 4'd15, 16'h8000, 16'h0004); expect_wb("asr");
        push(4'd1,  16'h1234, 16'h0004); issue(MOV, 4'd1,  16'h1234, 16'h0000); expect_wb("mov");

        // CMP: flags only.
        issue(CMP, 4'd2, 16'd7, 16'd7);
        chk("cmp storeNow", storeNow, 0);
        chk("cmp PSW", ProcessorStatusWord, 16'h0002);
        chk("cmp destVal", destVal, 16'h1234);

        // Opcode 4: multiply when enabled, NOP otherwise.
`ifdef EXEC_MUL_EN
        push(4'd11, 16'h5F90, 16'h0000);
        issue(MUL, 4'd11, 16'd300, 16'd300);
        expect_wb("mul");
`else
        issue(MUL, 4'd11, 16'd300, 16'd300);
        chk("mul_nop storeNow", storeNow, 0);
        chk("mul_nop PSW", ProcessorStatusWord, PSW_AFTER_MUL);
`endif

        // LOAD with three wait cycles; instructions during the wait are ignored.
        push(4'd8, 16'h1234, PSW_AFTER_MUL);
        issue(LD, 4'd8, 16'd0, 16'd0, 1'b0, 1'b0, 8'd26);
        chk("load readReq", readReq, 1);
        chk("load addr", memAddrLoadStore, 8'd26);
        chk("load writeReq", writeReq, 0);
        for (int i = 0; i < 3; i++) begin
            issue(ADD, 4'd3, 16'd1, 16'd1);
            chk("load wait readReq", readReq, 1);
            chk("load wait storeNow", storeNow, 0);
        end
        memValueLoad = 16'h1234;
        valueReady   = 1'b1;
        issue(NOP);
        valueReady   = 1'b0;
        expect_wb("load_done");
        chk("load readReq cleared", readReq, 0);

        // Loaded value is the forwarded last result.
        push(4'd9, 16'h1235, 16'h0000);
        issue(ADD, 4'd9, 16'h0000, 16'd1, 1'b1, 1'b0);
        expect_wb("fwd_load");

        // STORE held until memory completes.
        issue(ST, 4'd0, 16'd789, 16'd0, 1'b0, 1'b0, 8'd45);
        chk("store writeReq", writeReq, 1);
        chk("store readReq", readReq, 0);
        chk("store data", memValueStore, 16'd789);
        chk("store addr", memAddrLoadStore, 8'd45);
        for (int i = 0; i < 2; i++) begin
            issue(ADD, 4'd3, 16'd1, 16'd1);
            chk("store wait writeReq", writeReq, 1);
            chk("store wait storeNow", storeNow, 0);
        end
        valueReady = 1'b1;
        issue(NOP);
        valueReady = 1'b0;
        chk("store writeReq cleared", writeReq, 0);
        chk("store no wb", storeNow, 0);

        // HALT with a pending write that retires afterwards.
        storeDone = 1'b0;
        push(4'd10, 16'd5, 16'h0000);
        issue(ADD, 4'd10, 16'd2, 16'd3);
        expect_wb("pre_halt");
        issue(HLT);
        chk("halt powerdown", powerdown, 1);
        chk("halt pending storeNow", storeNow, 1);
        issue(ADD, 4'd11, 16'd1, 16'd1);
        chk("halt ignores destVal", destVal, 16'd5);
        chk("halt ignores PSW", ProcessorStatusWord, 16'h0000);
        storeDone = 1'b1;
        issue(NOP);
        chk("halt storeNow retired", storeNow, 0);
        issue(ADD, 4'd11, 16'hFFFF, 16'hFFFF);
        chk("halt sticky", powerdown, 1);
        chk("halt no wb", storeNow, 0);

        // Asynchronous reset out of HALT.
        #2 rst = 1'b0;
        #1 chk("reset from halt", all_outs(), 0);
        release_reset();

        // Reset in the middle of a load aborts it.
        issue(LD, 4'd2, 16'd0, 16'd0, 1'b0, 1'b0, 8'h10);
        chk("load2 readReq", readReq, 1);
        #2 rst = 1'b0;
        #1 chk("reset mid load", all_outs(), 0);
        release_reset();

        // Back in EXEC after reset.
        push(4'd12, 16'd54, 16'h0000);
        issue(ADD, 4'd12, 16'd24, 16'd30);
        expect_wb("post_reset_add");

        chk("scoreboard drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
